// File: rtl/julia_pkg.sv
// julia_pkg: shared fixed-point defaults, feeder state encoding and job constants.
package julia_pkg;
  localparam int DEF_FRACTIONAL = 10;
  localparam int DEF_INTEGRAL = 10;
  localparam int DEF_WIDTH = DEF_FRACTIONAL + DEF_INTEGRAL;
  typedef logic signed [DEF_WIDTH-1:0] fixed_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} feeder_state_t;
  localparam logic [7:0] ITER_INIT = 8'd0;
endpackage

// File: rtl/julia_raster_counter.sv
// julia_raster_counter: raster x/y position with line-wrap and last-pixel flags.
module julia_raster_counter import julia_pkg::*; #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  localparam int XW = $clog2(H_PIXELS),
  localparam int YW = $clog2(V_PIXELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_end,
  output logic          last
);
  assign line_end = x == XW'(H_PIXELS - 1);
  assign last = line_end && y == YW'(V_PIXELS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance && !last) begin
      x <= line_end ? '0 : x + 1'b1;
      y <= line_end ? y + 1'b1 : y;
    end
endmodule

// File: rtl/julia_pixel_feeder.sv
// julia_pixel_feeder: raster-order Julia job issuer with accumulated fixed-point z.
// Optional abort input enabled by JULIA_FEEDER_ABORT_EN.
module julia_pixel_feeder import julia_pkg::*; #(
  parameter int FRACTIONAL = DEF_FRACTIONAL,
  parameter int INTEGRAL = DEF_INTEGRAL,
  parameter int WIDTH = FRACTIONAL + INTEGRAL,
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  localparam int XW = $clog2(H_PIXELS),
  localparam int YW = $clog2(V_PIXELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
`ifdef JULIA_FEEDER_ABORT_EN
  input  logic                    abort,
`endif
  input  logic signed [WIDTH-1:0] real_min,
  input  logic signed [WIDTH-1:0] imag_max,
  input  logic signed [WIDTH-1:0] real_step,
  input  logic signed [WIDTH-1:0] imag_step,
  input  logic signed [WIDTH-1:0] c_real_in,
  input  logic signed [WIDTH-1:0] c_imag_in,
  input  logic                    ready_in,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] z_real_out,
  output logic signed [WIDTH-1:0] z_imag_out,
  output logic signed [WIDTH-1:0] c_real_out,
  output logic signed [WIDTH-1:0] c_imag_out,
  output logic [7:0]              iteration_out,
  output logic [XW-1:0]           pixel_x_out,
  output logic [YW-1:0]           pixel_y_out,
  output logic                    busy,
  output logic                    frame_done
);
  feeder_state_t state, state_n;
  logic signed [WIDTH-1:0] real_min_q, real_step_q, imag_step_q;
  logic kill, xfer, go, adv, line_end, last;
`ifdef JULIA_FEEDER_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  assign xfer = valid_out && ready_in;
  assign go = state == IDLE && start && !kill;
  assign adv = xfer && !kill;
  assign iteration_out = ITER_INIT;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // abort outranks both a pending transfer and the DONE pulse
  always_comb begin
    state_n = state == IDLE ? (go ? RUN : IDLE)
            : state == RUN && !kill ? (xfer && last ? DONE : RUN)
            : IDLE;
    valid_out = state == RUN;
    busy = state != IDLE;
    frame_done = state == DONE && !kill;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      real_min_q <= '0;
      real_step_q <= '0;
      imag_step_q <= '0;
      z_real_out <= '0;
      z_imag_out <= '0;
      c_real_out <= '0;
      c_imag_out <= '0;
    end else if (go) begin
      real_min_q <= real_min;
      real_step_q <= real_step;
      imag_step_q <= imag_step;
      z_real_out <= real_min;
      z_imag_out <= imag_max;
      c_real_out <= c_real_in;
      c_imag_out <= c_imag_in;
    end else if (adv && !last) begin
      z_real_out <= line_end ? real_min_q : z_real_out + real_step_q;
      if (line_end) z_imag_out <= z_imag_out - imag_step_q;
    end
  julia_raster_counter #(.H_PIXELS(H_PIXELS), .V_PIXELS(V_PIXELS)) u_raster (
    .clk(clk),
    .rst(rst),
    .clear(go),
    .advance(adv),
    .x(pixel_x_out),
    .y(pixel_y_out),
    .line_end(line_end),
    .last(last)
  );
endmodule

// File: tb/tb_julia_pixel_feeder.sv
// tb_julia_pixel_feeder: directed checks of raster order, stalls, latching, wrap and reset.
module tb_julia_pixel_feeder;
  logic clk = 1'b0;
  logic rst, start, ready_in;
  logic [19:0] real_min, imag_max, real_step, imag_step, c_real_in, c_imag_in;
  logic valid_out, busy, frame_done;
  logic [19:0] z_real_out, z_imag_out, c_real_out, c_imag_out;
  logic [7:0] iteration_out;
  logic [1:0] pixel_x_out, pixel_y_out;
`ifdef JULIA_FEEDER_ABORT_EN
  logic abort = 1'b0;
`endif
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  julia_pixel_feeder #(.H_PIXELS(4), .V_PIXELS(3)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef JULIA_FEEDER_ABORT_EN
    .abort(abort),
`endif
    .real_min(real_min),
    .imag_max(imag_max),
    .real_step(real_step),
    .imag_step(imag_step),
    .c_real_in(c_real_in),
    .c_imag_in(c_imag_in),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .z_real_out(z_real_out),
    .z_imag_out(z_imag_out),
    .c_real_out(c_real_out),
    .c_imag_out(c_imag_out),
    .iteration_out(iteration_out),
    .pixel_x_out(pixel_x_out),
    .pixel_y_out(pixel_y_out),
    .busy(busy),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, valid_out, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_done"}, frame_done, 0);
  endtask

  // mode 0: ready always; 1: ready toggles; 2: start re-pulsed mid-frame; 3: abort at 5th job
  task automatic run_frame(input logic [19:0] rmin, imax, rs, is, cr, ci, input int mode);
    int k, cyc;
    logic [19:0] ezr, ezi;
    @(negedge clk);
    real_min = rmin; imag_max = imax; real_step = rs; imag_step = is;
    c_real_in = cr; c_imag_in = ci; start = 1'b1; ready_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start valid", valid_out, 1);
    chk("start busy", busy, 1);
    real_min = 20'h12345; imag_max = 20'h54321; real_step = 20'h00777; imag_step = 20'h00999;
    c_real_in = 20'h0ABCD; c_imag_in = 20'h0DCBA;
    k = 0;
    cyc = 0;
    while (k < 12 && cyc < 100) begin
`ifdef JULIA_FEEDER_ABORT_EN
      if (mode == 3 && k == 4) begin
        abort = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort next");
        @(negedge clk);
        chk_idle("abort after");
        return;
      end
`endif
      ready_in = mode == 1 ? (cyc % 2) == 1 : 1'b1;
      start = mode == 2 && k == 5;
      ezr = rmin + rs * 20'(k % 4);
      ezi = imax - is * 20'(k / 4);
      chk("run valid", valid_out, 1);
      chk("z_real", z_real_out, ezr);
      chk("z_imag", z_imag_out, ezi);
      chk("pixel_x", pixel_x_out, k % 4);
      chk("pixel_y", pixel_y_out, k / 4);
      chk("c_real", c_real_out, cr);
      chk("c_imag", c_imag_out, ci);
      chk("iteration", iteration_out, 0);
      chk("run frame_done", frame_done, 0);
      if (valid_out && ready_in) k++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("job count", k, 12);
    chk("done valid", valid_out, 0);
    chk("done pulse", frame_done, 1);
    chk("done busy", busy, 1);
    @(negedge clk);
    chk_idle("post done");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready_in = 1'b0;
    real_min = '0; imag_max = '0; real_step = '0; imag_step = '0; c_real_in = '0; c_imag_in = '0;
    @(negedge clk);
    chk_idle("reset");
    chk("reset z_real", z_real_out, 0);
    chk("reset c_real", c_real_out, 0);
    chk("reset pixel_x", pixel_x_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle after reset");
    run_frame(20'hFF800, 20'h00400, 20'h00200, 20'h00200, 20'h00133, 20'hFFE00, 0);
    run_frame(20'hFF800, 20'h00400, 20'h00200, 20'h00200, 20'h00100, 20'h00080, 1);
    run_frame(20'hFF800, 20'h00400, 20'h00200, 20'h00200, 20'h003C0, 20'hFFF00, 2);
    run_frame(20'h7FE00, 20'h00000, 20'h00400, 20'h00100, 20'h00010, 20'h00020, 0);
    // asynchronous reset in the middle of a frame
    @(negedge clk);
    real_min = 20'hFF800; imag_max = 20'h00400; real_step = 20'h00200; imag_step = 20'h00200;
    c_real_in = 20'h00111; start = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset pixel_x", pixel_x_out, 2);
    #2 rst = 1'b1;
    #1;
    chk_idle("async reset");
    chk("async z_real", z_real_out, 0);
    chk("async z_imag", z_imag_out, 0);
    chk("async c_real", c_real_out, 0);
    chk("async pixel_x", pixel_x_out, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle("after abort by reset");
    end
`ifdef JULIA_FEEDER_ABORT_EN
    run_frame(20'hFF800, 20'h00400, 20'h00200, 20'h00200, 20'h00055, 20'h00066, 3);
    run_frame(20'hFF800, 20'h00400, 20'h00200, 20'h00200, 20'h00055, 20'h00066, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/julia_pixel_feeder.md
Name: julia_pixel_feeder

Overview:
- Initiator side of the per-pixel Julia compute interface.
- Walks the screen in raster order and generates the starting z coordinate for each pixel in fixed point.
- Pairs each z with the frame constant c and an initial iteration count of 0, then issues one job per pixel to the iteration pipeline over a valid/ready handshake.
- Reports frame progress and completion to the frame controller.

Parameters:
- WIDTH, 20, total signed fixed-point width of z/c values.
- FRACTIONAL, 10, fractional bits of WIDTH.
- INTEGRAL, 10, integral bits; WIDTH = FRACTIONAL + INTEGRAL.
- H_PIXELS, 640, pixels per line.
- V_PIXELS, 480, lines per frame.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame start request.
- real_min  in  WIDTH  signed real coordinate of pixel x=0.
- imag_max  in  WIDTH  signed imaginary coordinate of line y=0.
- real_step  in  WIDTH  signed real increment per pixel.
- imag_step  in  WIDTH  signed imaginary decrement per line.
- c_real_in  in  WIDTH  signed Julia constant, real part.
- c_imag_in  in  WIDTH  signed Julia constant, imaginary part.
- ready_in  in  1  downstream accepts the current job.
- valid_out  out  1  job on the outputs is valid.
- z_real_out  out  WIDTH  starting z, real part.
- z_imag_out  out  WIDTH  starting z, imaginary part.
- c_real_out  out  WIDTH  latched c, real part.
- c_imag_out  out  WIDTH  latched c, imaginary part.
- iteration_out  out  8  initial iteration count; always 0.
- pixel_x_out  out  $clog2(H_PIXELS)  x of the current job.
- pixel_y_out  out  $clog2(V_PIXELS)  y of the current job.
- busy  out  1  high in RUN and DONE.
- frame_done  out  1  one-cycle pulse after the last job transfers.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: valid_out, busy, frame_done, z/c outputs, pixel_x_out, pixel_y_out. iteration_out is constant 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch real_min, imag_max, real_step, imag_step, c_real_in and c_imag_in into registers.
  - Set z_real=real_min, z_imag=imag_max, x=0, y=0.
  - Go to RUN; valid_out=1 on the next cycle (1-cycle start-to-valid latency).
- RUN:
  - Transfer occurs when valid_out && ready_in in the same cycle.
  - While valid_out=1 and ready_in=0, all job outputs hold stable.
  - valid_out stays high for the whole RUN state, so back-to-back transfers give one job per clock.
- On a transfer, when x < H_PIXELS-1: x+=1, z_real+=real_step.
- On a transfer, when x = H_PIXELS-1 and y < V_PIXELS-1: x=0, z_real=real_min, y+=1, z_imag-=imag_step.
- On a transfer of the last pixel (x=H_PIXELS-1, y=V_PIXELS-1): valid_out=0 next cycle; go to DONE.
- DONE: frame_done=1 for exactly one cycle, then go to IDLE; busy=0 from that point.
- start is ignored while busy=1. Input coordinate changes during a frame have no effect, because all of them are latched.
- Arithmetic: WIDTH-bit two's-complement add/subtract, wrap on overflow, no saturation. Coordinates are accumulated, not multiplied.
- Reset asserted mid-frame aborts immediately. No frame_done is produced.

Optional Feature:
- Macro JULIA_FEEDER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN or DONE forces IDLE on the next edge: valid_out=0, busy=0, no frame_done pulse.
  - abort has priority over a simultaneous transfer, and over start in IDLE.
- Undefined: no abort port; a frame can only end by completion or rst.

Decomposition:
- Shared package julia_pkg holds:
  - WIDTH/FRACTIONAL/INTEGRAL defaults;
  - typedef logic signed [WIDTH-1:0] fixed_t;
  - feeder state enum {IDLE, RUN, DONE};
  - constant ITER_INIT = 8'd0.
- One sub-module is natural: julia_raster_counter, the x/y counters with line-wrap and last-pixel flags. The fixed-point accumulators and the FSM stay in the top.

Test Plan (H_PIXELS=4, V_PIXELS=3, FRACTIONAL=10):
- Reset with rst=1 held mid-cycle → all outputs 0 asynchronously; IDLE after release.
- start with real_min=-2048 (-2.0), imag_max=1024 (1.0), real_step=512, imag_step=512, ready_in=1 → 12 consecutive transfers.
  - Line 0 z_real: -2048, -1536, -1024, -512.
  - Line 1: z_real=-2048, z_imag=512; line 2: z_imag=0.
  - frame_done pulses 1 cycle after the 12th transfer.
- ready_in toggled 0/1 every cycle → outputs stable while stalled; still exactly 12 jobs, same coordinate sequence.
- start pulsed during RUN, and c_real_in changed mid-frame → ignored; c_real_out keeps the latched value for all 12 jobs.
- real_min=0x7FE00, real_step=0x00400 → z_real wraps to 0x80200 on the second pixel, with no saturation.
- With JULIA_FEEDER_ABORT_EN: abort at the 5th job → valid_out=0 and busy=0 next cycle, no frame_done; a new start produces the full 12 jobs.
